bitwise_logic_pipe: RTL and testbench
=====================================

# bitwise_logic_pipe

Parametrised, two-stage pipelined bitwise logic unit. It generalises the single-bit inverter to WIDTH-bit operands and eight selectable bitwise operations, with valid/ready flow control on both sides. It sits in the ALU datapath beside the adder and shifter, and its result feeds the ALU output mux.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 1..64
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  unit can accept a beat this cycle
- op  input  3  operation select, encodings listed under Operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; ignored by NOT_A and PASS_A
- out_valid  output  1  result beat offered
- out_ready  input  1  downstream accepts the result
- result  output  WIDTH  operation result
- zero  output  1  result is all zeros; present only with the flags macro
- parity  output  1  XOR-reduction of result; present only with the flags macro

## Operation
- Op encodings:
  - 0 NOT_A: ~a
  - 1 AND: a&b
  - 2 OR: a|b
  - 3 XOR: a^b
  - 4 NAND: ~(a&b)
  - 5 NOR: ~(a|b)
  - 6 XNOR: ~(a^b)
  - 7 PASS_A: a
- The operation is purely bitwise. There is no carry, and the result width equals WIDTH.
- Stage S1 registers op, a and b, plus s1_valid.
- Stage S2 registers the computed result (and flags, if enabled), plus s2_valid.
- Each stage keeps one valid bit. Occupancy is 0..2 beats.
- An input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- S2 loads when S2 is empty or out_ready=1. It loads the S1 contents, or clears s2_valid if S1 is empty.
- S1 loads when S1 is empty or S2 is loading. It loads the input beat on an input transfer; otherwise it clears s1_valid.
- in_ready = !s1_valid || s2_load. This path is combinational from out_ready.
- Stalled data holds stable. result, op and flags must not change while out_valid=1 and out_ready=0.
- Full (both stages valid, out_ready=0): in_ready=0, and no beat is lost or duplicated.
- Simultaneous accept and emit while full: the beats shift by one and throughput is preserved.
- Reset mid-operation discards all in-flight beats.
- Out-of-range op cannot occur, because the field is 3 bits and all encodings are defined.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1. It is therefore visible two cycles after presentation.
- Throughput: one beat per cycle when out_ready is held at 1.
- Reset values:
  - s1_valid=0, s2_valid=0, out_valid=0
  - result=0, zero=0, parity=0
  - in_ready=1 while rst is deasserted with an empty pipe
- While rst=1, in_ready is forced to 0.

## Configuration
- Macro: BITWISE_LOGIC_PIPE_FLAGS_EN.
- Defined:
  - zero and parity ports exist.
  - Both are computed from the S2 result input and registered alongside result, so they share its latency.
- Undefined:
  - The ports and flag registers are removed.
  - All other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - the op localparams (OP_NOT_A..OP_PASS_A)
  - the 3-bit op width constant, shared with the ALU top-level decoder
- One sub-module, bitwise_logic_core. It is combinational, takes op, a and b, and produces WIDTH-bit y. It is instantiated between S1 and S2.

## Test plan
- WIDTH=8, out_ready=1, sweep op 0..7 with a=0xA5, b=0x0F:
  - expect 0x5A, 0x05, 0xAF, 0xAA, 0xFA, 0x50, 0x55, 0xA5
  - each result arrives 2 cycles after its input
- Back-to-back: 16 consecutive beats with in_valid=1 and out_ready=1 produce 16 results on 16 consecutive cycles, in order.
- Backpressure: hold out_ready=0 for 5 cycles while offering 4 beats.
  - in_ready drops after 2 accepts.
  - result holds the first beat.
  - releasing out_ready drains beats in order with none lost.
- Reset mid-stream: assert rst asynchronously with 2 beats in flight.
  - out_valid drops to 0 immediately.
  - result=0.
  - after release, the first new beat emerges with 2-cycle latency.
- Flags (macro defined), XOR with a=b=0x3C:
  - result=0x00, zero=1, parity=0
  - then OR with a=0x01, b=0x02: result=0x03, zero=0, parity=0
  - then PASS_A with a=0x07: result=0x07, parity=1

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the op-select width and the bitwise operation encodings
// used by the logic unit and the ALU top-level decoder.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOT_A = 3'd0;
    localparam logic [OP_W-1:0] OP_AND   = 3'd1;
    localparam logic [OP_W-1:0] OP_OR    = 3'd2;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
    localparam logic [OP_W-1:0] OP_NOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS_A = 3'd7;

endpackage

// File: rtl/bitwise_logic_core.sv
// Combinational bitwise operator: selects one of eight WIDTH-bit logic functions of a and b.
module bitwise_logic_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_NOT_A:  y_o = ~a_i;
            OP_AND:    y_o = a_i & b_i;
            OP_OR:     y_o = a_i | b_i;
            OP_XOR:    y_o = a_i ^ b_i;
            OP_NAND:   y_o = ~(a_i & b_i);
            OP_NOR:    y_o = ~(a_i | b_i);
            OP_XNOR:   y_o = ~(a_i ^ b_i);
            OP_PASS_A: y_o = a_i;
            default:   y_o = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit (S1 operands, S2 result).
// Define BITWISE_LOGIC_PIPE_FLAGS_EN to add registered zero/parity result flags.
module bitwise_logic_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);

    logic             s1Valid_q;
    logic [OP_W-1:0]  s1Op_q;
    logic [WIDTH-1:0] s1A_q;
    logic [WIDTH-1:0] s1B_q;
    logic             s2Valid_q;
    logic [WIDTH-1:0] s2Result_q;
    logic [WIDTH-1:0] s2Result_d;

    logic s2Load;
    logic s1Load;
    logic inFire;

    // S2 advances whenever its beat leaves or it is empty; S1 follows S2.
    assign s2Load   = !s2Valid_q || out_ready;
    assign s1Load   = !s1Valid_q || s2Load;
    assign in_ready = !rst && s1Load;
    assign inFire   = in_valid && in_ready;

    bitwise_logic_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op_i(s1Op_q),
        .a_i (s1A_q),
        .b_i (s1B_q),
        .y_o (s2Result_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Op_q    <= '0;
            s1A_q     <= '0;
            s1B_q     <= '0;
        end else if (s1Load) begin
            s1Valid_q <= inFire;
            if (inFire) begin
                s1Op_q <= op;
                s1A_q  <= a;
                s1B_q  <= b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q  <= 1'b0;
            s2Result_q <= '0;
        end else if (s2Load) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Result_q <= s2Result_d;
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign result    = s2Result_q;

`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
    logic s2Zero_q;
    logic s2Parity_q;

    // Flags are taken from the same value S2 captures, so they track result exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Zero_q   <= 1'b0;
            s2Parity_q <= 1'b0;
        end else if (s2Load && s1Valid_q) begin
            s2Zero_q   <= (s2Result_d == '0);
            s2Parity_q <= ^s2Result_d;
        end
    end

    assign zero   = s2Zero_q;
    assign parity = s2Parity_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe (WIDTH=8); flag checks active with BITWISE_LOGIC_PIPE_FLAGS_EN.
module tb_bitwise_logic_pipe;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
    logic             zero;
    logic             parity;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             parity;
        int               cyc;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   lastAcceptCyc = 0;
    bit   latCheck = 1'b0;

    bitwise_logic_pipe #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
        ,
        .zero     (zero),
        .parity   (parity)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every beat the DUT hands over is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no output", result);
            end else begin
                e = expQ.pop_front();
                checkOutput("result", 64'(result), 64'(e.data));
`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
                checkOutput("zero", 64'(zero), 64'(e.zero));
                checkOutput("parity", 64'(parity), 64'(e.parity));
`endif
                if (latCheck) checkOutput("latency", 64'(cycle - e.cyc), 64'd2);
            end
        end
    end

    // Offer one beat and record its expected response once the DUT takes it.
    task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                 input logic [WIDTH-1:0] expData, input logic expZero, input logic expPar);
        int  waitCyc = 0;
        bit  done = 1'b0;
        exp_t e;
        op = o;
        a = aa;
        b = bb;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = expData;
                e.zero = expZero;
                e.parity = expPar;
                e.cyc = cycle;
                expQ.push_back(e);
                lastAcceptCyc = cycle;
                done = 1'b1;
            end else if (++waitCyc > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles, expected acceptance");
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d beats outstanding, expected 0", expQ.size());
        end
    endtask

    logic [WIDTH-1:0] sweepExp [8] = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5};

    initial begin
        int firstCyc;
        logic [WIDTH-1:0] v;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a = '0;
        b = '0;

        #2;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
`ifdef BITWISE_LOGIC_PIPE_FLAGS_EN
        checkOutput("reset_zero", 64'(zero), 64'd0);
        checkOutput("reset_parity", 64'(parity), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
        checkOutput("idle_out_valid", 64'(out_valid), 64'd0);

        // Op sweep, a=0xA5 b=0x0F; every result has even parity.
        @(posedge clk);
        #1 latCheck = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 8'hA5, 8'h0F, sweepExp[i], 1'b0, 1'b0);
        end
        waitDrain();

        // Back-to-back PASS_A stream with nibble-duplicated operands (even parity).
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            v = {4'(i), 4'(i)};
            applyStimulus(3'd7, v, 8'h00, v, (i == 0), 1'b0);
            if (i == 0) firstCyc = lastAcceptCyc;
        end
        checkOutput("b2b_accept_span", 64'(lastAcceptCyc - firstCyc), 64'd15);
        waitDrain();
        latCheck = 1'b0;

        // Backpressure: out_ready low for 5 cycles while 4 beats are offered.
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                applyStimulus(3'd3, 8'h12, 8'h34, 8'h26, 1'b0, 1'b1);
                applyStimulus(3'd1, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
                applyStimulus(3'd2, 8'h81, 8'h18, 8'h99, 1'b0, 1'b0);
                applyStimulus(3'd5, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                checkOutput("bp_in_ready_full", 64'(in_ready), 64'd0);
                checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
                checkOutput("bp_hold0", 64'(result), 64'h26);
                @(negedge clk);
                checkOutput("bp_hold1", 64'(result), 64'h26);
                @(negedge clk);
                checkOutput("bp_hold2", 64'(result), 64'h26);
                checkOutput("bp_in_ready_still", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();

        // Reset with two beats in flight.
        @(posedge clk);
        #1;
        applyStimulus(3'd7, 8'h11, 8'h00, 8'h11, 1'b0, 1'b0);
        applyStimulus(3'd7, 8'h22, 8'h00, 8'h22, 1'b0, 1'b0);
        checkOutput("pre_reset_out_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_result", 64'(result), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 latCheck = 1'b1;
        applyStimulus(3'd0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
        applyStimulus(3'd4, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0);
        waitDrain();

        // Flag-oriented vectors (flags compared only when the feature is built in).
        @(posedge clk);
        #1;
        applyStimulus(3'd3, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0);
        applyStimulus(3'd2, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        applyStimulus(3'd7, 8'h07, 8'h00, 8'h07, 1'b0, 1'b1);
        waitDrain();
        latCheck = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
